// File: rtl/fpu_pkg.sv
// Shared opcodes, default latencies and sequencer state encoding for the
// CombinedFPU command front-end.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MAC = 3'b111;
  localparam logic [2:0] OP_NOP = 3'b100;

  localparam int LAT_ADD_DEF = 6;
  localparam int LAT_MUL_DEF = 5;
  localparam int LAT_DIV_DEF = 5;
  localparam int LAT_MAC_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MAC: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Show-ahead command FIFO; pointers carry one extra wrap bit to tell full
// from empty.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 103
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Buffers FPU commands, holds each on the FPU inputs for its fixed latency and
// returns the captured result with its tag over a valid/ready handshake.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int LAT_ADD    = LAT_ADD_DEF,
  parameter int LAT_MUL    = LAT_MUL_DEF,
  parameter int LAT_DIV    = LAT_DIV_DEF,
  parameter int LAT_MAC    = LAT_MAC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_in_op,
  input  logic [31:0]      i_in_a,
  input  logic [31:0]      i_in_b,
  input  logic [31:0]      i_in_c,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic [2:0]       o_fpu_op,
  output logic [31:0]      o_fpu_a,
  output logic [31:0]      o_fpu_b,
  output logic [31:0]      o_fpu_c,
  input  logic [31:0]      i_fpu_result,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_result,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_out_err,
  output logic             o_busy
);

  localparam int CMD_W = 3 + 96 + TAG_W;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [CMD_W-1:0] w_din;
  logic [CMD_W-1:0] w_dout;
  logic [2:0]       w_head_op;
  logic [31:0]      w_head_a;
  logic [31:0]      w_head_b;
  logic [31:0]      w_head_c;
  logic [TAG_W-1:0] w_head_tag;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [2:0]       w_op_next;
  logic [31:0]      r_a;
  logic [31:0]      w_a_next;
  logic [31:0]      r_b;
  logic [31:0]      w_b_next;
  logic [31:0]      r_c;
  logic [31:0]      w_c_next;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] w_tag_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [31:0]      r_out_result;
  logic [31:0]      w_out_result_next;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] w_out_tag_next;
  logic             r_out_err;
  logic             w_out_err_next;

  function automatic logic [3:0] lat_of(input logic [2:0] op);
    logic [3:0] lat;
    case (op)
      OP_MUL:  lat = 4'(LAT_MUL);
      OP_DIV:  lat = 4'(LAT_DIV);
      OP_MAC:  lat = 4'(LAT_MAC);
      default: lat = 4'(LAT_ADD);
    endcase
    return lat;
  endfunction

  assign w_din  = {i_in_op, i_in_a, i_in_b, i_in_c, i_in_tag};
  assign {w_head_op, w_head_a, w_head_b, w_head_c, w_head_tag} = w_dout;
  assign w_push = i_in_valid && !w_full;

  fpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A new command issues from IDLE, or straight out of HOLD on the handshake edge.
  assign w_issue = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_out_ready));

  always_comb begin
    w_state_next      = r_state;
    w_op_next         = r_op;
    w_a_next          = r_a;
    w_b_next          = r_b;
    w_c_next          = r_c;
    w_tag_next        = r_tag;
    w_cnt_next        = r_cnt;
    w_out_result_next = r_out_result;
    w_out_tag_next    = r_out_tag;
    w_out_err_next    = r_out_err;
    w_pop             = 1'b0;

    case (r_state)
      ST_IDLE: begin
      end
      ST_RUN: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_out_result_next = i_fpu_result;
          w_out_tag_next    = r_tag;
          w_out_err_next    = 1'b0;
          w_op_next         = OP_NOP;
          w_a_next          = '0;
          w_b_next          = '0;
          w_c_next          = '0;
          w_state_next      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_out_ready && w_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_issue) begin
      w_pop      = 1'b1;
      w_tag_next = w_head_tag;
      if (is_legal_op(w_head_op)) begin
        w_op_next    = w_head_op;
        w_a_next     = w_head_a;
        w_b_next     = w_head_b;
        w_c_next     = w_head_c;
        w_cnt_next   = lat_of(w_head_op);
        w_state_next = ST_RUN;
      end else begin
        // Illegal opcodes never reach the FPU; they are answered immediately.
        w_op_next         = OP_NOP;
        w_a_next          = '0;
        w_b_next          = '0;
        w_c_next          = '0;
        w_out_result_next = '0;
        w_out_tag_next    = w_head_tag;
        w_out_err_next    = 1'b1;
        w_state_next      = ST_HOLD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_NOP;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_op         <= w_op_next;
      r_a          <= w_a_next;
      r_b          <= w_b_next;
      r_c          <= w_c_next;
      r_tag        <= w_tag_next;
      r_cnt        <= w_cnt_next;
      r_out_result <= w_out_result_next;
      r_out_tag    <= w_out_tag_next;
      r_out_err    <= w_out_err_next;
    end
  end

  assign o_in_ready   = !w_full;
  assign o_fpu_op     = r_op;
  assign o_fpu_a      = r_a;
  assign o_fpu_b      = r_b;
  assign o_fpu_c      = r_c;
  assign o_out_valid  = (r_state == ST_HOLD);
  assign o_out_result = r_out_result;
  assign o_out_tag    = r_out_tag;
  assign o_out_err    = r_out_err;
  assign o_busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
